decode_buffered: RTL
====================

# decode_buffered

Buffered, parametrised instruction decode stage for the out-of-order core. Raw 32-bit RV32I instructions and their PCs arrive over a valid/ready handshake into a DEPTH-entry FIFO. The head entry is decoded into the register-index/immediate/control bundle and registered in a one-entry output slot with its own valid/ready handshake toward rename/dispatch. The stage also supports a synchronous pipeline flush and sign-extended immediates.

## Interface
- XLEN, 32, datapath and immediate width; 32 or 64.
- PC_W, 32, PC tag width.
- DEPTH, 4, instruction FIFO entries; power of 2, ≥2.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous; discard all buffered and output-slot instructions.
- in_valid  in  1  instruction offered.
- in_ready  out  1  = (count < DEPTH) && !flush.
- in_inst  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts bundle.
- out_pc  out  PC_W  PC of decoded instruction.
- opcode  out  7  inst[6:0].
- rs1  out  5  inst[19:15].
- rs2  out  5  inst[24:20].
- rd  out  5  inst[11:7].
- imm  out  XLEN  sign-extended immediate.
- alu_op  out  3  ALU operation: 000 ADD, 001 SUB, 010 XOR, 011 SRA, 100 AND.
- alu_src  out  1  1 = use imm as operand B.
- mem_to_reg  out  1  writeback from memory.
- reg_write  out  1  writes rd.
- mem_read  out  1  load.
- mem_write  out  1  store.
- illegal  out  1  unrecognised encoding; tied 0 without the macro.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output slot.

## Operation
- FIFO:
  - Push on in_valid && in_ready.
  - Pop when FIFO non-empty && (!out_valid || out_ready); on pop, the decoded head loads the output slot and out_valid=1.
  - If out_valid && out_ready and the FIFO is empty, out_valid clears.
- Decode is combinational on the FIFO head.
  - rs1, rs2, rd and opcode are always passed through from their instruction fields.
- Recognised encodings:
  - ADD: 0110011, f3 000, f7 0000000. alu_op 000, reg_write.
  - SUB: 0110011, f3 000, f7 0100000. alu_op 001, reg_write.
  - XOR: 0110011, f3 100, f7 0000000. alu_op 010, reg_write.
  - SRA: 0110011, f3 101, f7 0100000. alu_op 011, reg_write.
  - ADDI: 0010011, f3 000. alu_op 000, alu_src, reg_write, imm = sext(inst[31:20]).
  - ANDI: 0010011, f3 111. alu_op 100, alu_src, reg_write, imm = sext(inst[31:20]).
  - LW: 0000011, f3 010. alu_op 000, alu_src, mem_to_reg, mem_read, reg_write, imm = sext(inst[31:20]).
  - SW: 0100011, f3 010. alu_op 000, alu_src, mem_write, imm = sext({inst[31:25],inst[11:7]}).
- All other encodings decode as NOP:
  - Control bits 0, alu_op 000, imm 0.
  - Still emitted with out_valid=1; illegal per Configuration.
- R-type decodes drive imm 0 and alu_src 0.

## Timing
- Reset (async, rst_n low): FIFO pointers 0, count 0, out_valid 0. All bundle outputs, out_pc and illegal are 0. in_ready goes to 1 after release.
- Latency: instruction pushed at edge E0 (empty stage) appears with out_valid=1 after edge E1.
- Sustained throughput: 1 instruction/cycle with out_ready held 1.
- Full: count==DEPTH forces in_ready=0 even if a pop occurs that cycle; no same-cycle pass-through.
- Total stage capacity is DEPTH+1 instructions.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged.
- Pointers wrap modulo DEPTH.
- Flush:
  - At the next edge, count=0, pointers=0, out_valid=0.
  - Flush has priority over a same-cycle push (in_ready is 0) and over a same-cycle pop or load.
  - Bundle outputs hold their values but are meaningless while out_valid=0.
- Bundle stability: while out_valid && !out_ready, all bundle outputs and out_pc are held stable.
- Reset mid-operation discards all contents immediately.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: illegal=1 on any NOP-decoded encoding, registered with the bundle. All-zero and all-one instruction words count as illegal.
- Undefined: illegal is constant 0 and unrecognised encodings pass silently as NOP.

## Test plan
- ADD x3,x1,x2 (0x002081B3), out_ready=1 → after two edges: rs1=1, rs2=2, rd=3, alu_op=000, reg_write=1, alu_src=0, imm=0.
- ADDI x5,x0,-1 (0xFFF00293) then LW x4,-4(x1) (0xFFC0A203), XLEN=32:
  - ADDI → imm=0xFFFFFFFF, alu_src=1.
  - LW → imm=0xFFFFFFFC, mem_read=1, mem_to_reg=1.
- SW x2,8(x1) (0x0020A423) → imm=8, mem_write=1, reg_write=0.
- DEPTH=4, out_ready=0, push 6 instructions back-to-back:
  - 5 accepted, then in_ready=0 and count=4; 6th is held by the source.
  - Release out_ready → all 5 emitted in order, one per cycle, with matching out_pc.
- Fill with 3 entries, assert flush with in_valid=1 for one cycle → next cycle count=0, out_valid=0; the flush-cycle instruction is never emitted.
- With DECODE_ILLEGAL_TRAP_EN: 0x00000000 → out_valid=1, illegal=1, all control bits 0. Without the macro: same bundle, illegal=0.

Source files
------------

// File: rtl/decode_buffered.sv
// RV32I decode stage: DEPTH-entry instruction FIFO feeding a registered decode slot.
// Define DECODE_ILLEGAL_TRAP_EN to flag unrecognised encodings on `illegal`.
module decode_buffered #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [6:0]                 opcode,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            imm,
  output logic [2:0]                 alu_op,
  output logic                       alu_src,
  output logic                       mem_to_reg,
  output logic                       reg_write,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SRA = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] v);
    sext12 = {{(XLEN-12){v[11]}}, v};
  endfunction

  logic [31:0]     inst_p0 [DEPTH];
  logic [PC_W-1:0] pc_p0   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;

  assign in_ready = (count < CW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!out_valid || out_ready) && !flush;

  // ---- stage p0: instruction FIFO ----
  always_ff @(posedge clk) begin
    if (push) begin
      inst_p0[wr_ptr] <= in_inst;
      pc_p0[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [31:0]            head;
  logic [6:0]             opc;
  logic [2:0]             f3;
  logic [6:0]             f7;
  logic [2:0]             dec_alu_op;
  logic                   dec_alu_src, dec_mem_to_reg, dec_reg_write;
  logic                   dec_mem_read, dec_mem_write, dec_nop;
  logic signed [XLEN-1:0] dec_imm;

  assign head = inst_p0[rd_ptr];
  assign opc  = head[6:0];
  assign f3   = head[14:12];
  assign f7   = head[31:25];

  always_comb begin
    dec_alu_op     = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_imm        = '0;
    dec_nop        = 1'b0;
    case (opc)
      OPC_R: begin
        dec_reg_write = 1'b1;
        if      (f3 == 3'b000 && f7 == 7'b0000000) dec_alu_op = ALU_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) dec_alu_op = ALU_SUB;
        else if (f3 == 3'b100 && f7 == 7'b0000000) dec_alu_op = ALU_XOR;
        else if (f3 == 3'b101 && f7 == 7'b0100000) dec_alu_op = ALU_SRA;
        else begin
          dec_reg_write = 1'b0;
          dec_nop       = 1'b1;
        end
      end
      OPC_I: begin
        if (f3 == 3'b000 || f3 == 3'b111) begin
          dec_alu_op    = (f3 == 3'b111) ? ALU_AND : ALU_ADD;
          dec_alu_src   = 1'b1;
          dec_reg_write = 1'b1;
          dec_imm       = sext12(head[31:20]);
        end else begin
          dec_nop = 1'b1;
        end
      end
      OPC_LD: begin
        if (f3 == 3'b010) begin
          dec_alu_src    = 1'b1;
          dec_mem_to_reg = 1'b1;
          dec_mem_read   = 1'b1;
          dec_reg_write  = 1'b1;
          dec_imm        = sext12(head[31:20]);
        end else begin
          dec_nop = 1'b1;
        end
      end
      OPC_ST: begin
        if (f3 == 3'b010) begin
          dec_alu_src   = 1'b1;
          dec_mem_write = 1'b1;
          dec_imm       = sext12({head[31:25], head[11:7]});
        end else begin
          dec_nop = 1'b1;
        end
      end
      default: dec_nop = 1'b1;
    endcase
  end

  // ---- stage p1: registered decode slot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      opcode     <= '0;
      rs1        <= '0;
      rs2        <= '0;
      rd         <= '0;
      imm        <= '0;
      alu_op     <= '0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_pc     <= pc_p0[rd_ptr];
      opcode     <= opc;
      rs1        <= head[19:15];
      rs2        <= head[24:20];
      rd         <= head[11:7];
      imm        <= dec_imm;
      alu_op     <= dec_alu_op;
      alu_src    <= dec_alu_src;
      mem_to_reg <= dec_mem_to_reg;
      reg_write  <= dec_reg_write;
      mem_read   <= dec_mem_read;
      mem_write  <= dec_mem_write;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             illegal <= 1'b0;
    else if (!flush && pop) illegal <= dec_nop;
  end
`else
  logic unused_nop;
  assign unused_nop = dec_nop;
  assign illegal    = 1'b0;
`endif

endmodule
